// File: rtl/memory_arbiter_if.sv
// Memory-side handshake bundle shared by the I-cache, D-cache, main memory and the arbiter.
// The master modport is the arbiter's view; slave is the view of the caches and memory around it.
interface memory_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              IMEM_READ;
  logic [ADDR_W-1:0] IMEM_ADDRESS;
  logic [DATA_W-1:0] IMEM_READDATA;
  logic              IMEM_BUSYWAIT;
  logic              DMEM_READ;
  logic              DMEM_WRITE;
  logic [ADDR_W-1:0] DMEM_ADDRESS;
  logic [DATA_W-1:0] DMEM_WRITEDATA;
  logic [DATA_W-1:0] DMEM_READDATA;
  logic              DMEM_BUSYWAIT;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [DATA_W-1:0] MEM_WRITEDATA;
  logic [DATA_W-1:0] MEM_READDATA;
  logic              MEM_BUSYWAIT;

  modport master (
    input  IMEM_READ, IMEM_ADDRESS,
    output IMEM_READDATA, IMEM_BUSYWAIT,
    input  DMEM_READ, DMEM_WRITE, DMEM_ADDRESS, DMEM_WRITEDATA,
    output DMEM_READDATA, DMEM_BUSYWAIT,
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    input  MEM_READDATA, MEM_BUSYWAIT
  );

  modport slave (
    output IMEM_READ, IMEM_ADDRESS,
    input  IMEM_READDATA, IMEM_BUSYWAIT,
    output DMEM_READ, DMEM_WRITE, DMEM_ADDRESS, DMEM_WRITEDATA,
    input  DMEM_READDATA, DMEM_BUSYWAIT,
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    output MEM_READDATA, MEM_BUSYWAIT
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester arbiter for the block-interface main memory: one transaction at a time,
// alternating priority on simultaneous misses, one-cycle completion window per owner.
module memory_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              CLK,
  input  logic              RESET,
  memory_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  logic              op_q, op_d;
  logic              cyc_q, cyc_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic i_req_s;
  logic d_req_s;

  assign i_req_s = bus.IMEM_READ;
  assign d_req_s = bus.DMEM_READ | bus.DMEM_WRITE;

  // Next-state, grant latching and read-data capture
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    op_d         = op_q;
    cyc_d        = cyc_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        // D wins when alone, or on a tie when I held the memory last
        if (d_req_s && (!i_req_s || (last_owner_q == OWN_I))) begin
          owner_d     = OWN_D;
          op_d        = bus.DMEM_WRITE;
          mem_read_d  = ~bus.DMEM_WRITE;
          mem_write_d = bus.DMEM_WRITE;
          mem_addr_d  = bus.DMEM_ADDRESS;
          mem_wdata_d = bus.DMEM_WRITEDATA;
          cyc_d       = 1'b0;
          state_d     = ST_GRANT;
        end else if (i_req_s) begin
          owner_d     = OWN_I;
          op_d        = 1'b0;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = bus.IMEM_ADDRESS;
          cyc_d       = 1'b0;
          state_d     = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // Memory busywait is not trusted on the first grant edge
        if (!cyc_q) begin
          cyc_d = 1'b1;
        end else if (!bus.MEM_BUSYWAIT) begin
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          last_owner_d = owner_q;
          state_d      = ST_RESP;
          if (!op_q) begin
            if (owner_q == OWN_D) begin
              d_rdata_d = bus.MEM_READDATA;
            end else begin
              i_rdata_d = bus.MEM_READDATA;
            end
          end else begin
            d_rdata_d = d_rdata_q;
          end
        end else begin
          state_d = ST_GRANT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      op_q         <= 1'b0;
      cyc_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      op_q         <= op_d;
      cyc_q        <= cyc_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.MEM_READ      = mem_read_q;
  assign bus.MEM_WRITE     = mem_write_q;
  assign bus.MEM_ADDRESS   = mem_addr_q;
  assign bus.MEM_WRITEDATA = mem_wdata_q;
  assign bus.IMEM_READDATA = i_rdata_q;
  assign bus.DMEM_READDATA = d_rdata_q;

  // A requester is released only in the RESP cycle of its own transaction
  assign bus.IMEM_BUSYWAIT = i_req_s & ~((state_q == ST_RESP) & (owner_q == OWN_I));
  assign bus.DMEM_BUSYWAIT = d_req_s & ~((state_q == ST_RESP) & (owner_q == OWN_D));

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus random traffic, every cycle compared
// against a transaction-level reference model of the arbitration rules.
module tb_memory_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one outstanding transaction, its age in edges, and the returned blocks
  bit          m_busy = 1'b0, m_resp = 1'b0, m_owner = 1'b0, m_write = 1'b0, m_last = 1'b0;
  int          m_age = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_ird = '0, m_drd = '0;

  // Memory stub and grant log
  int          lat = 0;
  int          mb_cnt = 0;
  bit          rnd_bw = 1'b0;
  bit          prev_act = 1'b0;
  logic [AW-1:0] grants[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] gq(input int i);
    return (i < grants.size()) ? grants[i] : '1;
  endfunction

  task automatic model_edge();
    bit ir, dr;
    if (!RESET) begin
      m_busy = 1'b0; m_resp = 1'b0; m_last = 1'b0; m_owner = 1'b0; m_age = 0;
      m_addr = '0; m_wdata = '0; m_ird = '0; m_drd = '0;
    end else if (m_resp) begin
      m_resp = 1'b0;
    end else if (m_busy) begin
      m_age++;
      if (m_age >= 2 && !bus.MEM_BUSYWAIT) begin
        m_busy = 1'b0;
        m_resp = 1'b1;
        m_last = m_owner;
        if (!m_write) begin
          if (m_owner) m_drd = bus.MEM_READDATA;
          else         m_ird = bus.MEM_READDATA;
        end
      end
    end else begin
      ir = bus.IMEM_READ;
      dr = bus.DMEM_READ | bus.DMEM_WRITE;
      if (ir || dr) begin
        m_owner = (ir && dr) ? ~m_last : dr;
        m_busy  = 1'b1;
        m_age   = 0;
        if (m_owner) begin
          m_write = bus.DMEM_WRITE;
          m_addr  = bus.DMEM_ADDRESS;
          m_wdata = bus.DMEM_WRITEDATA;
        end else begin
          m_write = 1'b0;
          m_addr  = bus.IMEM_ADDRESS;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("mem_read",  DW'(bus.MEM_READ),  DW'(m_busy && !m_write));
    chk("mem_write", DW'(bus.MEM_WRITE), DW'(m_busy && m_write));
    chk("mem_addr",  DW'(bus.MEM_ADDRESS), DW'(m_addr));
    chk("mem_wdata", bus.MEM_WRITEDATA, m_wdata);
    chk("i_rdata",   bus.IMEM_READDATA, m_ird);
    chk("d_rdata",   bus.DMEM_READDATA, m_drd);
    chk("i_bw", DW'(bus.IMEM_BUSYWAIT), DW'(bus.IMEM_READ && !(m_resp && !m_owner)));
    chk("d_bw", DW'(bus.DMEM_BUSYWAIT),
        DW'((bus.DMEM_READ || bus.DMEM_WRITE) && !(m_resp && m_owner)));
  endtask

  task automatic cycle();
    bit act;
    @(posedge CLK);
    model_edge();
    #1;
    compare_all();
    act = bus.MEM_READ | bus.MEM_WRITE;
    if (act && !prev_act) grants.push_back(bus.MEM_ADDRESS);
    prev_act = act;
    if (act) mb_cnt++;
    else     mb_cnt = 0;
    if (rnd_bw) bus.MEM_BUSYWAIT = 1'($urandom_range(0, 1));
    else        bus.MEM_BUSYWAIT = (mb_cnt < lat);
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    RESET = 1'b1;
  endtask

  initial begin
    int  low;
    bit  seen;
    logic [DW-1:0] saved;

    bus.IMEM_READ = 1'b0; bus.IMEM_ADDRESS = '0;
    bus.DMEM_READ = 1'b0; bus.DMEM_WRITE = 1'b0; bus.DMEM_ADDRESS = '0; bus.DMEM_WRITEDATA = '0;
    bus.MEM_READDATA = '0; bus.MEM_BUSYWAIT = 1'b0;
    #2;

    // Reset held two cycles while the I-cache requests
    bus.IMEM_READ = 1'b1;
    bus.IMEM_ADDRESS = 28'h0000010;
    RESET = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_mem_read", DW'(bus.MEM_READ), DW'(1'b0));
      chk("rst_i_bw", DW'(bus.IMEM_BUSYWAIT), DW'(1'b1));
      chk("rst_i_rdata", bus.IMEM_READDATA, DW'(0));
    end

    // Single I read with a slow memory
    bus.MEM_READDATA = {16{8'hA5}};
    lat = 4;
    grants.delete();
    RESET = 1'b1;
    low = 0;
    for (int i = 0; i < 9; i++) begin
      cycle();
      if (!bus.IMEM_BUSYWAIT) low++;
    end
    chk("i_single_low_cycles", DW'(low), DW'(1));
    chk("i_single_addr", DW'(gq(0)), DW'(28'h0000010));
    chk("i_single_data", bus.IMEM_READDATA, {16{8'hA5}});
    bus.IMEM_READ = 1'b0;
    for (int i = 0; i < 10; i++) cycle();

    // Simultaneous misses from reset: D first, then strict alternation while both persist
    do_reset(1);
    lat = 0;
    bus.MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
    bus.IMEM_READ = 1'b1; bus.IMEM_ADDRESS = 28'h0000010;
    bus.DMEM_READ = 1'b1; bus.DMEM_ADDRESS = 28'h0000020;
    grants.delete();
    for (int i = 0; i < 18; i++) cycle();
    chk("alt_count", DW'(grants.size() >= 4), DW'(1'b1));
    chk("alt_g0_d", DW'(gq(0)), DW'(28'h0000020));
    chk("alt_g1_i", DW'(gq(1)), DW'(28'h0000010));
    chk("alt_g2_d", DW'(gq(2)), DW'(28'h0000020));
    chk("alt_g3_i", DW'(gq(3)), DW'(28'h0000010));
    bus.IMEM_READ = 1'b0; bus.DMEM_READ = 1'b0;
    for (int i = 0; i < 8; i++) cycle();

    // D write-back; write data changes under the grant
    lat = 2;
    saved = m_drd;
    bus.DMEM_WRITE = 1'b1; bus.DMEM_ADDRESS = 28'h0000030;
    bus.DMEM_WRITEDATA = {8{16'h1234}};
    grants.delete();
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (bus.MEM_WRITE) begin
        chk("wr_mem_data", bus.MEM_WRITEDATA, {8{16'h1234}});
        bus.DMEM_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
      end
      if (bus.DMEM_WRITE && !bus.DMEM_BUSYWAIT) bus.DMEM_WRITE = 1'b0;
    end
    chk("wr_addr", DW'(gq(0)), DW'(28'h0000030));
    chk("wr_rdata_kept", bus.DMEM_READDATA, saved);

    // Both D strobes high: a write wins
    seen = 1'b0;
    bus.DMEM_READ = 1'b1; bus.DMEM_WRITE = 1'b1; bus.DMEM_ADDRESS = 28'h0000040;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (!seen && (bus.MEM_READ || bus.MEM_WRITE)) begin
        seen = 1'b1;
        chk("both_mem_write", DW'(bus.MEM_WRITE), DW'(1'b1));
        chk("both_mem_read", DW'(bus.MEM_READ), DW'(1'b0));
      end
      if ((bus.DMEM_READ || bus.DMEM_WRITE) && !bus.DMEM_BUSYWAIT) begin
        bus.DMEM_READ = 1'b0; bus.DMEM_WRITE = 1'b0;
      end
    end
    chk("both_seen", DW'(seen), DW'(1'b1));

    // Reset during a D read grant: access abandoned, next tie goes to D
    do_reset(2);
    lat = 3;
    bus.MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
    bus.DMEM_READ = 1'b1; bus.DMEM_ADDRESS = 28'h0000050;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      cycle();
      seen = bus.MEM_READ;
    end
    chk("mid_rst_granted", DW'(seen), DW'(1'b1));
    RESET = 1'b0;
    cycle();
    chk("mid_rst_mem_read", DW'(bus.MEM_READ), DW'(1'b0));
    chk("mid_rst_d_rdata", bus.DMEM_READDATA, DW'(0));
    RESET = 1'b1;
    lat = 0;
    bus.IMEM_READ = 1'b1; bus.IMEM_ADDRESS = 28'h0000060;
    grants.delete();
    for (int i = 0; i < 4; i++) cycle();
    chk("mid_rst_tie_d", DW'(gq(0)), DW'(28'h0000050));
    bus.IMEM_READ = 1'b0; bus.DMEM_READ = 1'b0;
    for (int i = 0; i < 8; i++) cycle();

    // Random traffic, busy memory and occasional resets
    rnd_bw = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      RESET = ($urandom_range(0, 99) != 0);
      bus.IMEM_READ = ($urandom_range(0, 2) == 0);
      bus.DMEM_READ = ($urandom_range(0, 2) == 0);
      bus.DMEM_WRITE = ($urandom_range(0, 3) == 0);
      bus.IMEM_ADDRESS = AW'($urandom);
      bus.DMEM_ADDRESS = AW'($urandom);
      bus.DMEM_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
      bus.MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
